axi4_pixel_port: RTL and testbench

// - Synthesizable AXI4-lite slave that feeds image bytes to the CPU. It replaces the

---
 rtl/axi4_pixel_port_if.sv | 29 ++
 rtl/axi4_pixel_port.sv | 147 ++++++++++++++
 tb/tb_axi4_pixel_port.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pixel_port_if.sv
// AXI4-lite register bus between the CPU and the pixel port.
// Holds only the five AXI channels; clock, reset and pixel stream stay plain ports.
interface axi4_pixel_port_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi4_pixel_port.sv
// AXI4-lite slave: a byte FIFO filled from a valid/ready pixel stream, popped by DATA reads.
// Define PIXEL_PORT_STATS_EN to build the 32-bit POPCNT counter at offset 0x1C.
module axi4_pixel_port #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic               clk,
    input  logic               rst,
    axi4_pixel_port_if.slave   s_axi,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [7:0]         pix_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [4:0] OFF_DATA   = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h14;
    localparam logic [4:0] OFF_CTRL   = 5'h18;
    localparam logic [4:0] OFF_POPCNT = 5'h1C;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          run_reg;
    logic          empty, full, push, pop, flush, popcnt_clr;

    logic          awready_reg, wready_reg, bvalid_reg, aw_held_reg, w_held_reg;
    logic [31:0]   awaddr_reg;
    logic          wbit0_reg;
    logic          arready_reg, rvalid_reg;
    logic [31:0]   rdata_reg, rdata_next;
    logic [31:0]   popcnt_val;

    logic          aw_hs, w_hs, ar_hs, aw_have, w_have, commit;
    logic          aw_held_next, w_held_next, bvalid_next, rvalid_next;
    logic [31:0]   wr_addr;
    logic          wr_bit0, wr_sel, rd_sel;
    logic          unused_bits;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
    // run_reg keeps pix_ready low through reset and for the cycle rst falls
    assign pix_ready = run_reg && !full;
    assign push      = pix_valid && pix_ready;

    assign s_axi.awready = awready_reg;
    assign s_axi.wready  = wready_reg;
    assign s_axi.bvalid  = bvalid_reg;
    assign s_axi.arready = arready_reg;
    assign s_axi.rvalid  = rvalid_reg;
    assign s_axi.rdata   = rdata_reg;

    assign unused_bits = ^{s_axi.wstrb, s_axi.wdata[31:1]};

    // Read channel
    assign ar_hs       = s_axi.arvalid && arready_reg;
    assign rvalid_next = ar_hs || (rvalid_reg && !s_axi.rready);
    assign rd_sel      = (s_axi.araddr[31:5] == BASE_ADDR[31:5]);
    assign pop         = ar_hs && rd_sel && (s_axi.araddr[4:0] == OFF_DATA) && !empty;

    always_comb begin
        rdata_next = '0;
        if (rd_sel) begin
            case (s_axi.araddr[4:0])
                OFF_DATA:   rdata_next = empty ? 32'hFFFF_FFFF : {24'b0, mem[rd_ptr_reg]};
                OFF_STATUS: rdata_next = {empty, full, 14'b0, 16'(count_reg)};
                OFF_POPCNT: rdata_next = popcnt_val;
                default:    rdata_next = '0;
            endcase
        end
    end

    // Write channel: AW and W latch independently; the register effect lands when both are in
    assign aw_hs        = s_axi.awvalid && awready_reg;
    assign w_hs         = s_axi.wvalid && wready_reg;
    assign aw_have      = aw_held_reg || aw_hs;
    assign w_have       = w_held_reg || w_hs;
    assign commit       = aw_have && w_have;
    assign aw_held_next = aw_have && !commit;
    assign w_held_next  = w_have && !commit;
    assign bvalid_next  = commit || (bvalid_reg && !s_axi.bready);
    assign wr_addr      = aw_hs ? s_axi.awaddr : awaddr_reg;
    assign wr_bit0      = w_hs ? s_axi.wdata[0] : wbit0_reg;
    assign wr_sel       = (wr_addr[31:5] == BASE_ADDR[31:5]);
    assign flush        = commit && wr_sel && (wr_addr[4:0] == OFF_CTRL) && wr_bit0;
    assign popcnt_clr   = commit && wr_sel && (wr_addr[4:0] == OFF_POPCNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_reg     <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wbit0_reg   <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            run_reg     <= 1'b1;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            bvalid_reg  <= bvalid_next;
            awready_reg <= !aw_held_next && !bvalid_next;
            wready_reg  <= !w_held_next && !bvalid_next;
            if (aw_hs) awaddr_reg <= s_axi.awaddr;
            if (w_hs)  wbit0_reg  <= s_axi.wdata[0];
            rvalid_reg  <= rvalid_next;
            arready_reg <= !rvalid_next;
            if (ar_hs) rdata_reg <= rdata_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Storage kept free of reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr_reg] <= pix_data;
    end

`ifdef PIXEL_PORT_STATS_EN
    logic [31:0] popcnt_reg;
    always_ff @(posedge clk) begin
        if (rst || flush || popcnt_clr) popcnt_reg <= '0;
        else if (pop)                   popcnt_reg <= popcnt_reg + 32'd1;
    end
    assign popcnt_val = popcnt_reg;
`else
    assign popcnt_val = '0;
`endif
endmodule

// File: tb/tb_axi4_pixel_port.sv
// Directed bench for axi4_pixel_port: a vector table for the register map plus
// hand-written sequences for fill/full, push+pop wrap, flush with a stalled read and AW/W skew.
module tb_axi4_pixel_port;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h10;
    localparam logic [31:0] A_STAT = BASE + 32'h14;
    localparam logic [31:0] A_CTRL = BASE + 32'h18;
    localparam logic [31:0] A_PCNT = BASE + 32'h1C;
`ifdef PIXEL_PORT_STATS_EN
    localparam logic [31:0] EXP_POP3 = 32'd3;
    localparam logic [31:0] EXP_POP5 = 32'd5;
`else
    localparam logic [31:0] EXP_POP3 = 32'd0;
    localparam logic [31:0] EXP_POP5 = 32'd0;
`endif
    localparam int OP_PUSH = 0, OP_READ = 1, OP_WRITE = 2;
    localparam int NV = 20;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_valid, pix_ready;
    logic [7:0] pix_data;
    int checks = 0;
    int failures = 0;

    axi4_pixel_port_if bus();

    axi4_pixel_port dut (
        .clk(clk), .rst(rst), .s_axi(bus),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout got none expected handshake", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = b;
        while (!pix_ready && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("push_wait");
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        while (!bus.arready && n < 100) begin tick(); n++; end
        tick();
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            timeout("read_wait");
            d = 32'hxxxx_xxxx;
        end else begin
            d = bus.rdata;
        end
        tick();
        bus.rready = 1'b0;
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int lead, output int bcnt);
        int aw_start, w_start, c;
        bit aw_done, w_done, aw_hs, w_hs, b_hs;
        aw_start = (lead < 0) ? -lead : 0;
        w_start  = (lead > 0) ? lead : 0;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = 4'hF;
        bus.bready = 1'b1;
        bcnt = 0; aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done && bcnt > 0) && c < 100) begin
            bus.awvalid = !aw_done && (c >= aw_start);
            bus.wvalid  = !w_done && (c >= w_start);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (b_hs)  bcnt++;
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (c >= 100) timeout("write_wait");
        repeat (4) begin
            if (bus.bvalid) bcnt++;
            tick();
        end
    endtask

    vec_t vecs [NV];
    logic [31:0] rd;
    int bc;
    logic [7:0] exp_q[$];
    logic [7:0] next_byte;

    initial begin
        vecs[0]  = '{OP_PUSH,  32'h0,  32'h11, 32'h0};
        vecs[1]  = '{OP_PUSH,  32'h0,  32'h22, 32'h0};
        vecs[2]  = '{OP_PUSH,  32'h0,  32'h33, 32'h0};
        vecs[3]  = '{OP_READ,  A_STAT, 32'h0,  32'h0000_0003};
        vecs[4]  = '{OP_READ,  A_DATA, 32'h0,  32'h0000_0011};
        vecs[5]  = '{OP_READ,  A_DATA, 32'h0,  32'h0000_0022};
        vecs[6]  = '{OP_READ,  A_DATA, 32'h0,  32'h0000_0033};
        vecs[7]  = '{OP_READ,  A_DATA, 32'h0,  32'hFFFF_FFFF};
        vecs[8]  = '{OP_READ,  A_STAT, 32'h0,  32'h8000_0000};
        vecs[9]  = '{OP_READ,  A_PCNT, 32'h0,  EXP_POP3};
        vecs[10] = '{OP_WRITE, A_PCNT, 32'h1234, 32'h0};
        vecs[11] = '{OP_READ,  A_PCNT, 32'h0,  32'h0};
        vecs[12] = '{OP_READ,  A_CTRL, 32'h0,  32'h0};
        vecs[13] = '{OP_READ,  BASE,   32'h0,  32'h0};
        vecs[14] = '{OP_WRITE, BASE + 32'h4, 32'hDEAD_BEEF, 32'h0};
        vecs[15] = '{OP_PUSH,  32'h0,  32'h5A, 32'h0};
        vecs[16] = '{OP_WRITE, A_CTRL, 32'h0,  32'h0};
        vecs[17] = '{OP_READ,  A_STAT, 32'h0,  32'h0000_0001};
        vecs[18] = '{OP_READ,  A_DATA, 32'h0,  32'h0000_005A};
        vecs[19] = '{OP_READ,  A_STAT, 32'h0,  32'h8000_0000};

        rst = 1'b1;
        pix_valid = 1'b0; pix_data = 8'h0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
        bus.wstrb = 4'h0; bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready = 1'b0;
        repeat (3) tick();
        check("rst_outputs", {27'b0, pix_ready, bus.arready, bus.awready, bus.wready,
                              bus.bvalid | bus.rvalid}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        check("pix_ready_rst_fall", {31'b0, pix_ready}, 32'h0);
        tick();
        check("pix_ready_after", {31'b0, pix_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_PUSH:  push_byte(vecs[i].data[7:0]);
                OP_READ: begin
                    axi_read(vecs[i].addr, rd);
                    check($sformatf("vec%0d_read_%h", i, vecs[i].addr), rd, vecs[i].exp);
                end
                default: begin
                    axi_write(vecs[i].addr, vecs[i].data, 0, bc);
                    check($sformatf("vec%0d_bcount", i), bc, 32'd1);
                end
            endcase
        end

        // Fill to full with pix_valid held for a 17th byte
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        pix_valid = 1'b1;
        pix_data  = 8'h50;
        repeat (3) tick();
        check("full_pix_ready", {31'b0, pix_ready}, 32'h0);
        axi_read(A_STAT, rd);
        check("full_status", rd, 32'h4000_0010);
        axi_read(A_DATA, rd);
        check("full_pop", rd, 32'h0000_0040);
        repeat (3) tick();
        pix_valid = 1'b0;
        axi_read(A_STAT, rd);
        check("refill_status", rd, 32'h4000_0010);
        for (int i = 1; i < 17; i++) begin
            axi_read(A_DATA, rd);
            check($sformatf("drain_%0d", i), rd, (i == 16) ? 32'h50 : 32'h40 + 32'(i));
        end

        // Simultaneous push and pop at count 5, wrapping the pointers
        next_byte = 8'h80;
        for (int i = 0; i < 5; i++) begin
            push_byte(next_byte);
            exp_q.push_back(next_byte);
            next_byte++;
        end
        for (int i = 0; i < 35; i++) begin
            pix_valid   = 1'b1;
            pix_data    = next_byte;
            bus.araddr  = A_DATA;
            bus.arvalid = 1'b1;
            bus.rready  = 1'b1;
            if (!(pix_ready && bus.arready)) timeout("pushpop_ready");
            tick();
            exp_q.push_back(next_byte);
            next_byte++;
            pix_valid   = 1'b0;
            bus.arvalid = 1'b0;
            check($sformatf("pushpop_%0d", i), bus.rdata, {24'b0, exp_q.pop_front()});
            tick();
            bus.rready = 1'b0;
        end
        axi_read(A_STAT, rd);
        check("pushpop_count", rd, 32'h0000_0005);
        for (int i = 0; i < 5; i++) begin
            axi_read(A_DATA, rd);
            check($sformatf("pushpop_drain_%0d", i), rd, {24'b0, exp_q.pop_front()});
        end

        // Flush while full, with a DATA read stalled on rready
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        bus.araddr  = A_DATA;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        if (!bus.arready) timeout("flush_ar");
        tick();
        bus.arvalid = 1'b0;
        axi_write(A_CTRL, 32'h1, 0, bc);
        check("flush_bcount", bc, 32'd1);
        check("flush_rvalid_held", {31'b0, bus.rvalid}, 32'h1);
        check("flush_pre_head", bus.rdata, 32'h0000_0060);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        axi_read(A_STAT, rd);
        check("flush_status", rd, 32'h8000_0000);
        axi_read(A_PCNT, rd);
        check("flush_popcnt", rd, 32'h0);

        // Pop counter and skewed AW/W writes
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            axi_read(A_DATA, rd);
            check($sformatf("stats_pop_%0d", i), rd, 32'hA0 + 32'(i));
        end
        axi_read(A_PCNT, rd);
        check("popcnt_5", rd, EXP_POP5);
        axi_write(A_PCNT, 32'h0, 3, bc);
        check("aw_first_bcount", bc, 32'd1);
        axi_read(A_PCNT, rd);
        check("popcnt_cleared", rd, 32'h0);
        axi_write(A_CTRL, 32'h1, -3, bc);
        check("w_first_bcount", bc, 32'd1);
        axi_read(A_STAT, rd);
        check("final_status", rd, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
